pmod_spi_xfer: RTL

PMOD_SPI_XFER -- requirements
Module: pmod_spi_xfer

---
 rtl/pmod_spi_xfer_if.sv | 37 +++
 rtl/pmod_spi_xfer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pmod_spi_xfer_if.sv
// pmod_spi_xfer_if
// Bundles the request/data handshake and the SPI pins of one pmod_spi_xfer
// transfer engine.
//   sndRec : transaction request, rising-edge sensitive
//   din    : transmit bytes, byte 0 in the most significant position
//   dout   : received bytes, byte 0 in the most significant position
//   busy   : high while a transaction is in progress
//   done   : one-cycle pulse when a transaction completes
//   ss     : slave select, active low
//   sclk   : serial clock
//   mosi   : serial data to the slave
//   miso   : serial data from the slave
// The "master" modport is the host side that issues requests and serves MISO.
// The "slave" modport is the transfer engine that answers those requests.
interface pmod_spi_xfer_if #(
    parameter int NBYTES = 5
);
    logic                  sndRec;
    logic [8*NBYTES-1:0]   din;
    logic [8*NBYTES-1:0]   dout;
    logic                  busy;
    logic                  done;
    logic                  ss;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;

    modport master (
        output sndRec, din, miso,
        input  dout, busy, done, ss, sclk, mosi
    );

    modport slave (
        input  sndRec, din, miso,
        output dout, busy, done, ss, sclk, mosi
    );
endinterface

// File: rtl/pmod_spi_xfer.sv
// pmod_spi_xfer
// Multi-byte SPI master. A rising edge on sndRec captures din and clocks
// NBYTES bytes out on MOSI, MSB first, while shifting MISO in. SS stays low
// for the whole transaction. dout is updated in one step when the transfer
// completes.
// Ports:
//   clk_i  : system clock, the only clock domain
//   rst_ni : synchronous active-low reset
//   bus    : pmod_spi_xfer_if.slave (sndRec, din, dout, busy, done, ss, sclk,
//            mosi, miso)
// Timing is expressed in ticks. One tick lasts CLK_DIV clocks and equals one
// SCLK half-period.
module pmod_spi_xfer #(
    parameter int NBYTES   = 5,
    parameter int CLK_DIV  = 750,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0,
    parameter int SS_LEAD  = 1,
    parameter int BYTE_GAP = 4,
    parameter int SS_LAG   = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    pmod_spi_xfer_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int TW = $clog2(CLK_DIV);
    localparam int PW = 16;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [4:0]    LAST_BYTE = 5'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, LAG, DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [4:0]      byteIdx_q, byteIdx_d;
    logic [W-1:0]    tx_q, tx_d;
    logic [W-1:0]    rx_q, rx_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            sndRecSync_q, sndRecPrev_q;
    logic            ss_q, ss_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            startEdge;
    logic            tickEnd;
    logic            lastTick;
    logic            leadingEdge;
    logic            trailingEdge;
    logic            active;
    logic [PW-1:0]   phaseLimit;

    assign startEdge    = sndRecSync_q & ~sndRecPrev_q;
    assign tickEnd      = (tick_q == TICK_LAST);
    assign lastTick     = tickEnd && (phase_q == phaseLimit - 1'b1);
    // SHIFT ticks alternate leading/trailing halves; tick 0 ends with the leading edge
    assign leadingEdge  = (state_q == SHIFT) && tickEnd && !phase_q[0];
    assign trailingEdge = (state_q == SHIFT) && tickEnd &&  phase_q[0];

    // Number of ticks spent in the current state
    always_comb begin
        phaseLimit = PW'(1);
        case (state_q)
            LEAD:    phaseLimit = PW'(SS_LEAD);
            SHIFT:   phaseLimit = PW'(16);
            GAP:     phaseLimit = PW'(BYTE_GAP);
            LAG:     phaseLimit = PW'(SS_LAG);
            default: phaseLimit = PW'(1);
        endcase
    end

    // Next-state logic for the sequencer, the shifters and the registered pins
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        phase_d   = phase_q;
        byteIdx_d = byteIdx_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        active    = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d  = '0;
                phase_d = '0;
                if (startEdge) begin
                    state_d   = LEAD;
                    tx_d      = bus.din;
                    rx_d      = '0;
                    byteIdx_d = '0;
                    mosi_d    = 1'b0;
                end
            end
            LEAD, SHIFT, GAP, LAG: begin
                tick_d = tickEnd ? '0 : tick_q + 1'b1;
                if (tickEnd) begin
                    phase_d = lastTick ? '0 : phase_q + 1'b1;
                end
                if (lastTick) begin
                    case (state_q)
                        LEAD:  state_d = SHIFT;
                        SHIFT: begin
                            if (byteIdx_q == LAST_BYTE) begin
                                state_d = LAG;
                            end else begin
                                byteIdx_d = byteIdx_q + 1'b1;
                                state_d   = (BYTE_GAP == 0) ? SHIFT : GAP;
                            end
                        end
                        GAP:     state_d = SHIFT;
                        default: state_d = DONE;
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
                tick_d  = '0;
                phase_d = '0;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == SHIFT) && tickEnd) begin
            sclk_d = ~sclk_q;
        end

        if (CPHA ? trailingEdge : leadingEdge) begin
            rx_d = {rx_q[W-2:0], bus.miso};
        end

        // CPHA=0 presents bit 7 as SHIFT is entered, so the final trailing
        // edge of a byte only moves data when it also starts the next byte.
        if (CPHA ? leadingEdge
                 : ((lastTick && (state_d == SHIFT)) || (trailingEdge && !lastTick))) begin
            mosi_d = tx_q[W-1];
            tx_d   = {tx_q[W-2:0], 1'b0};
        end

        if ((state_d == IDLE) || (state_d == DONE)) begin
            mosi_d = 1'b0;
        end

        active = state_d inside {LEAD, SHIFT, GAP, LAG};
        ss_d   = !active;
        busy_d = active;
        done_d = (state_d == DONE);
        if (state_d == DONE) begin
            dout_d = rx_q;
        end
    end

    // State and output registers, cleared by the synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            phase_q      <= '0;
            byteIdx_q    <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            dout_q       <= '0;
            sndRecSync_q <= 1'b0;
            sndRecPrev_q <= 1'b0;
            ss_q         <= 1'b1;
            sclk_q       <= CPOL;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            phase_q      <= phase_d;
            byteIdx_q    <= byteIdx_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            dout_q       <= dout_d;
            sndRecSync_q <= bus.sndRec;
            sndRecPrev_q <= sndRecSync_q;
            ss_q         <= ss_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.ss   = ss_q;
    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;
endmodule
